ifu_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the NPC core. Owns the PC and drives the

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
//==============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction-fetch unit.
//               fetch_state_e : sequencer states (REQ, WAIT, HOLD, DRAIN)
//               RESET_PC_DEFAULT : default PC of the first fetch after reset
//               PC_STEP : byte distance between sequential instructions
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // request outstanding to inst memory, waiting for accept
    ST_WAIT  = 2'd1,  // request accepted, waiting for read data
    ST_HOLD  = 2'd2,  // instruction presented to decode
    ST_DRAIN = 2'd3   // discarding the response of a squashed request
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          PC_STEP          = 4;

endpackage : ifu_pkg

`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
//==============================================================================
// Module      : ifu_fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC, issues one
//               outstanding request at a time to the instruction memory,
//               presents each fetched word to decode over valid/ready and
//               squashes in-flight or held fetches on an EXU redirect.
// Ports       :
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   fetch request channel
//   imem_rsp_valid, imem_rsp_data     fetch response channel
//   inst_valid/ready, inst_pc/data    instruction channel to decode
//   redirect_valid, redirect_pc       branch/jump redirect from EXU
//   fetch_cnt                         instructions consumed by decode (wraps)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_cnt
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst_data;
  logic [31:0]       r_fetch_cnt;

  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_seq;

  // Redirect targets are forced word aligned; sequential PC wraps naturally.
  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_pc_seq      = r_pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_inst_data <= '0;
      r_fetch_cnt <= '0;
    end else begin
      // A redirect takes the PC in every state; the HOLD branch below only
      // advances sequentially when no redirect is present.
      if (redirect_valid) begin
        r_pc <= w_redirect_pc;
      end

      case (r_state)
        ST_REQ: begin
          // An accepted request under redirect belongs to the old stream and
          // its response must be thrown away before refetching.
          if (imem_req_ready) begin
            r_state <= redirect_valid ? ST_DRAIN : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            r_state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
          end else if (imem_rsp_valid) begin
            r_inst_data <= imem_rsp_data;
            r_state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Decode taking the word still counts even if it is squashed in
          // the same cycle; only the PC update yields to the redirect.
          if (inst_ready) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (!redirect_valid) begin
              r_pc <= w_pc_seq;
            end
          end
          if (inst_ready || redirect_valid) begin
            r_state <= ST_REQ;
          end
        end

        ST_DRAIN: begin
          // A redirect here only replaces the target PC. The outstanding
          // response still retires the stale request, so leave once it lands.
          if (imem_rsp_valid) begin
            r_state <= ST_REQ;
          end
        end

        default: r_state <= ST_REQ;
      endcase
    end
  end

  // Handshake valids are decoded from state and forced low during reset.
  assign imem_req_valid = (r_state == ST_REQ)  && !rst;
  assign inst_valid     = (r_state == ST_HOLD) && !rst;
  assign imem_addr      = r_pc;
  assign inst_pc        = r_pc;
  assign inst_data      = r_inst_data;
  assign fetch_cnt      = r_fetch_cnt;

  // Memory must only answer while a request is actually in flight.
  a_no_unexpected_rsp : assert property (
    @(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (r_state == ST_REQ || r_state == ST_HOLD))
  );

endmodule : ifu_fetch_ctrl

`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
//==============================================================================
// Module      : tb_ifu_fetch_ctrl
// Description : Scoreboard bench for ifu_fetch_ctrl. Directed stimulus pushes
//               expected fetch addresses and decoded instructions into queues;
//               a monitor pops and compares on every handshake. A small
//               memory model answers requests with a programmable latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  ifu_fetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h8000_0000)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  logic [31:0] exp_req_q[$];
  inst_t       exp_inst_q[$];

  int vectors;
  int miscompares;
  int mem_lat;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] a);
    inst_t e;
    e.pc   = a;
    e.data = rom(a);
    exp_inst_q.push_back(e);
  endtask

  task automatic wait_cnt(input logic [31:0] target, input int budget);
    int b;
    b = budget;
    while (fetch_cnt !== target && b > 0) begin
      step(1);
      b--;
    end
    check("fetch_cnt_reach", fetch_cnt, target);
  endtask

  task automatic wait_inst_valid(input int budget);
    int b;
    b = budget;
    while (inst_valid !== 1'b1 && b > 0) begin
      step(1);
      b--;
    end
    check("inst_valid_reach", {31'd0, inst_valid}, 32'd1);
  endtask

  // Memory model: decisions at the falling edge, response one or more
  // cycles after the accepting rising edge.
  initial begin
    logic [31:0] pend;
    int          cd;
    pend           = '0;
    cd             = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rom(pend);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          pend = imem_addr;
          cd   = mem_lat;
        end
      end
    end
  end

  // Monitor: every accepted request and every decode handshake is checked
  // against the head of the matching queue.
  initial begin
    logic [31:0] ea;
    inst_t       ei;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL req_unexpected: got addr %h, expected no request", imem_addr);
        end else begin
          ea = exp_req_q.pop_front();
          check("imem_addr", imem_addr, ea);
        end
      end
      if (!rst && inst_valid && inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL inst_unexpected: got pc %h data %h, expected none", inst_pc, inst_data);
        end else begin
          ei = exp_inst_q.pop_front();
          check("inst_pc", inst_pc, ei.pc);
          check("inst_data", inst_data, ei.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    mem_lat        = 1;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1: reset state and zero-wait streaming at one instruction per 3 cycles
    step(3);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h8000_0000);
    push_req(32'h8000_0000);
    push_req(32'h8000_0004);
    push_req(32'h8000_0008);
    push_req(32'h8000_000C);
    push_inst(32'h8000_0000);
    push_inst(32'h8000_0004);
    push_inst(32'h8000_0008);
    rst = 1'b0;
    step(8);
    check("stream_cnt_8cyc", fetch_cnt, 32'd2);
    step(1);
    check("stream_cnt_9cyc", fetch_cnt, 32'd3);

    // 2: decode stalls for 10 cycles in HOLD
    inst_ready = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) begin
      check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst_pc", inst_pc, 32'h8000_000C);
      check("hold_inst_data", inst_data, rom(32'h8000_000C));
      check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
      step(1);
    end
    push_inst(32'h8000_000C);
    push_req(32'h8000_0010);
    inst_ready = 1'b1;
    step(1);
    check("after_hold_addr", imem_addr, 32'h8000_0010);
    check("after_hold_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // 3: redirect in WAIT with a slow response; target low bits ignored
    mem_lat = 4;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step(1);
    redirect_valid = 1'b0;
    check("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("drain_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("drain_addr", imem_addr, 32'h8000_0100);
    mem_lat = 1;
    push_req(32'h8000_0100);
    push_inst(32'h8000_0100);
    wait_cnt(32'd5, 30);

    // 4: redirect together with inst_ready in HOLD
    inst_ready = 1'b0;
    push_req(32'h8000_0104);
    wait_inst_valid(20);
    check("hold2_pc", inst_pc, 32'h8000_0104);
    push_inst(32'h8000_0104);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    step(1);
    redirect_valid = 1'b0;
    check("redir_hold_cnt", fetch_cnt, 32'd6);
    check("redir_hold_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("redir_hold_addr", imem_addr, 32'h8000_2000);
    push_req(32'h8000_2000);
    push_inst(32'h8000_2000);
    wait_cnt(32'd7, 20);

    // 5: redirect in REQ while memory accepts: stale request drained
    push_req(32'h8000_2004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    step(1);
    redirect_valid = 1'b0;
    check("req_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("req_redir_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("req_redir_addr", imem_addr, 32'h8000_3000);
    push_req(32'h8000_3000);
    push_inst(32'h8000_3000);
    wait_cnt(32'd8, 20);

    // 6a: redirect in REQ without accept, then PC wrap at the top of memory
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step(1);
    redirect_valid = 1'b0;
    check("noacc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("noacc_addr", imem_addr, 32'hFFFF_FFFC);
    push_req(32'hFFFF_FFFC);
    push_inst(32'hFFFF_FFFC);
    push_req(32'h0000_0000);
    imem_req_ready = 1'b1;
    wait_cnt(32'd9, 20);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // 6b: reset while a request is in flight, then restart at RESET_PC
    step(1);
    rst = 1'b1;
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    step(1);
    check("midrst_req_valid2", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_addr", imem_addr, 32'h8000_0000);
    check("midrst_cnt", fetch_cnt, 32'd0);
    check("midrst_inst_data", inst_data, 32'd0);
    push_req(32'h8000_0000);
    push_inst(32'h8000_0000);
    rst = 1'b0;
    wait_cnt(32'd1, 20);
    imem_req_ready = 1'b0;
    step(3);

    check("req_q_empty", exp_req_q.size(), 32'd0);
    check("inst_q_empty", exp_inst_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ifu_fetch_ctrl

`default_nettype wire
